// File: rtl/exe_stage_controller.sv
// +--------------------------------------------------------------------------+
// | exe_stage_controller: EXE-stage NZCV owner, memory-stall freeze, flush    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module exe_stage_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic       exe_b,
  input  logic       exe_mem_r_en,
  input  logic       exe_mem_w_en,
  input  logic [3:0] alu_status,
  input  logic       mem_ready,
  output logic [3:0] sr,
  output logic       freeze,
  output logic       flush,
  output logic       br_taken,
  output logic       mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] c_timeout    = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_next;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_next;
  logic [3:0] r_sr;
  logic       r_mem_err;
  logic       w_err_next;
  logic       w_mem_op;
  logic       w_branch;
  logic       w_sr_we;

  assign w_mem_op = exe_valid & (exe_mem_r_en | exe_mem_w_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= 8'd0;
      r_flush_cnt <= 3'd0;
      r_sr        <= 4'b0000;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_next;
      r_flush_cnt <= w_flush_next;
      r_mem_err   <= w_err_next;
      if (w_sr_we)
        r_sr <= alu_status;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_flush_next = r_flush_cnt;
    w_err_next   = r_mem_err;
    w_branch     = 1'b0;
    freeze       = 1'b0;
    flush        = 1'b0;
    br_taken     = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_op && !mem_ready) begin
          freeze       = 1'b1;
          w_state_next = MEM_WAIT;
          w_wait_next  = 8'd1;
        end else if (exe_valid && exe_b && !w_mem_op) begin
          w_branch = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_state_next = RUN;
          w_wait_next  = 8'd0;
          w_branch     = exe_valid & exe_b;
        end else if (r_wait_cnt == c_timeout) begin
          // Abandon the access; the pipeline resumes and the error stays sticky.
          w_state_next = RUN;
          w_wait_next  = 8'd0;
          w_err_next   = 1'b1;
        end else begin
          freeze      = 1'b1;
          w_wait_next = r_wait_cnt + 8'd1;
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        w_flush_next = r_flush_cnt - 3'd1;
        if (r_flush_cnt == 3'd1)
          w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase

    if (w_branch) begin
      br_taken = 1'b1;
      flush    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_next = FLUSH;
        w_flush_next = c_flush_init;
      end
    end
  end

  // Slots inside a flush window are squashed, so they never touch the flags.
  assign w_sr_we = exe_valid & exe_s & ~freeze & (r_state != FLUSH);

  assign sr      = r_sr;
  assign mem_err = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage_controller.sv
// +--------------------------------------------------------------------------+
// | tb_exe_stage_controller: directed + random bench with behavioural model   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_exe_stage_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       exe_valid = 1'b0, exe_s = 1'b0, exe_b = 1'b0;
  logic       exe_mem_r_en = 1'b0, exe_mem_w_en = 1'b0;
  logic [3:0] alu_status = 4'b0000;
  logic       mem_ready = 1'b0;

  logic [3:0] sr_a, sr_b;
  logic       frz_a, fl_a, br_a, err_a;
  logic       frz_b, fl_b, br_b, err_b;

  always #5 clk = ~clk;

  exe_stage_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) u_a (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s), .exe_b(exe_b),
    .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .alu_status(alu_status), .mem_ready(mem_ready),
    .sr(sr_a), .freeze(frz_a), .flush(fl_a), .br_taken(br_a), .mem_err(err_a)
  );

  exe_stage_controller #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) u_b (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s), .exe_b(exe_b),
    .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .alu_status(alu_status), .mem_ready(mem_ready),
    .sr(sr_b), .freeze(frz_b), .flush(fl_b), .br_taken(br_b), .mem_err(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles already waited, flush cycles still owed, flags, error.
  int         p_fc[2] = '{2, 1};
  int         p_to[2] = '{15, 3};
  int         m_wait[2], m_fl[2];
  logic [3:0] m_sr[2];
  logic       m_err[2];
  int         nx_wait[2], nx_fl[2];
  logic [3:0] nx_sr[2];
  logic       nx_err[2];

  // Observed-event counters for u_a, used by the directed scenarios.
  int c_frz, c_fl, c_br;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_fl[k] = 0; m_sr[k] = 4'b0000; m_err[k] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic b,
                      input logic rd, input logic wr, input logic [3:0] st,
                      input logic rdy);
    @(negedge clk);
    rst = r; exe_valid = v; exe_s = s; exe_b = b;
    exe_mem_r_en = rd; exe_mem_w_en = wr; alu_status = st; mem_ready = rdy;
    #1;
    if (frz_a) c_frz++;
    if (fl_a)  c_fl++;
    if (br_a)  c_br++;
    for (int k = 0; k < 2; k++) begin
      logic e_frz, e_fl, e_br, taken, in_flush, mem_op;
      string  nm;
      nm = (k == 0) ? "u_a" : "u_b";
      e_frz = 1'b0; e_fl = 1'b0; e_br = 1'b0; taken = 1'b0;
      mem_op   = v && (rd || wr);
      in_flush = (m_fl[k] > 0);
      nx_wait[k] = m_wait[k]; nx_fl[k] = m_fl[k];
      nx_err[k] = m_err[k]; nx_sr[k] = m_sr[k];
      if (in_flush) begin
        e_fl = 1'b1;
        nx_fl[k] = m_fl[k] - 1;
      end else if (m_wait[k] > 0) begin
        if (rdy) begin
          nx_wait[k] = 0;
          taken = v && b;
        end else if (m_wait[k] == p_to[k]) begin
          nx_wait[k] = 0;
          nx_err[k] = 1'b1;
        end else begin
          e_frz = 1'b1;
          nx_wait[k] = m_wait[k] + 1;
        end
      end else begin
        if (mem_op && !rdy) begin
          e_frz = 1'b1;
          nx_wait[k] = 1;
        end else if (v && b && !mem_op) begin
          taken = 1'b1;
        end
      end
      if (taken) begin
        e_br = 1'b1; e_fl = 1'b1;
        nx_fl[k] = p_fc[k] - 1;
      end
      if (v && s && !e_frz && !in_flush)
        nx_sr[k] = st;
      chk({nm, " freeze"},   8'((k == 0) ? frz_a : frz_b), 8'(e_frz));
      chk({nm, " flush"},    8'((k == 0) ? fl_a  : fl_b),  8'(e_fl));
      chk({nm, " br_taken"}, 8'((k == 0) ? br_a  : br_b),  8'(e_br));
      chk({nm, " sr"},       8'((k == 0) ? sr_a  : sr_b),  8'(m_sr[k]));
      chk({nm, " mem_err"},  8'((k == 0) ? err_a : err_b), 8'(m_err[k]));
    end
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        m_wait[k] = nx_wait[k]; m_fl[k] = nx_fl[k];
        m_sr[k] = nx_sr[k]; m_err[k] = nx_err[k];
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and first status update.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    idle();
    chk("reset sr", 8'(sr_a), 8'h00);
    c_frz = 0; c_fl = 0; c_br = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    chk("adds sr", 8'(sr_a), 8'h06);
    chk("adds quiet", 8'(c_frz + c_fl + c_br), 8'd0);

    // Load stalled three cycles.
    c_frz = 0;
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b1);
    chk("ldr freeze cycles", 8'(c_frz), 8'd3);
    chk("ldr sr kept", 8'(sr_a), 8'h06);

    // Branch with a two-cycle flush; S-bit in the squashed slot is ignored.
    c_fl = 0; c_br = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
    idle();
    chk("br pulses", 8'(c_br), 8'd1);
    chk("br flush cycles", 8'(c_fl), 8'd2);
    chk("br sr kept", 8'(sr_a), 8'h06);

    // Load and branch together; branch resolves in the ready cycle.
    c_fl = 0; c_br = 0; c_frz = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("ldbr first cycle", 8'(c_fl + c_br), 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("ldbr br", 8'(c_br), 8'd1);
    chk("ldbr flush", 8'(c_fl), 8'd1);
    chk("ldbr freeze", 8'(c_frz), 8'd1);
    idle();
    idle();

    // Store with memory stuck: timeout after fifteen frozen cycles.
    c_frz = 0;
    repeat (16) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    chk("str freeze cycles", 8'(c_frz), 8'd15);
    chk("str mem_err", 8'(err_a), 8'd1);
    repeat (3) idle();
    chk("mem_err sticky", 8'(err_a), 8'd1);

    // Reset in the middle of a memory wait.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("rst sr", 8'(sr_a), 8'h00);
    chk("rst mem_err", 8'(err_a), 8'd0);
    c_frz = 0;
    idle();
    chk("rst freeze", 8'(c_frz), 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, v, s, b, rd, wr, rdy;
      logic [3:0] st;
      r   = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 9) < 8);
      s   = $urandom_range(0, 1);
      b   = ($urandom_range(0, 5) == 0);
      rd  = ($urandom_range(0, 4) == 0);
      wr  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 9) < 3);
      st  = 4'($urandom_range(0, 15));
      step(r, v, s, b, rd, wr, st, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
